// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the two accelerator channels, the arbiter and the memory.
// The slave modport is the arbiter's view; the master modport is the environment
// (accelerator channels plus memory) driving it.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 8,
    parameter int SIZE_W = 4
);
    logic [1:0]          ch_oe;
    logic [1:0]          ch_we;
    logic [2*ADDR_W-1:0] ch_addr;
    logic [2*DATA_W-1:0] ch_wdata;
    logic [2*SIZE_W-1:0] ch_size;
    logic [2*DATA_W-1:0] ch_rdata;
    logic [1:0]          ch_rdy;
    logic                mem_oe;
    logic                mem_we;
    logic [ADDR_W-1:0]   mem_addr;
    logic [DATA_W-1:0]   mem_wdata;
    logic [SIZE_W-1:0]   mem_size;
    logic [DATA_W-1:0]   mem_rdata;
    logic                mem_rdy;
    logic                err_conflict;
    logic                err_timeout;

    modport slave (
        input  ch_oe, ch_we, ch_addr, ch_wdata, ch_size, mem_rdata, mem_rdy,
        output ch_rdata, ch_rdy, mem_oe, mem_we, mem_addr, mem_wdata, mem_size,
               err_conflict, err_timeout
    );

    modport master (
        output ch_oe, ch_we, ch_addr, ch_wdata, ch_size, mem_rdata, mem_rdy,
        input  ch_rdata, ch_rdy, mem_oe, mem_we, mem_addr, mem_wdata, mem_size,
               err_conflict, err_timeout
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-channel round-robin arbiter in front of a single-port byte memory.
// One transaction in flight; the granted channel's live request is passed
// straight through while BUSY. A watchdog aborts a stalled memory access,
// and sticky flags record request conflicts and watchdog aborts.
module mem_port_arbiter #(
    parameter int ADDR_W         = 7,
    parameter int DATA_W         = 8,
    parameter int SIZE_W         = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clock,
    input  logic                  reset,
    mem_port_arbiter_if.slave     bus
);
    localparam int WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    state_t            state_reg, state_next;
    logic              grant_reg, grant_next;
    logic              last_grant_reg, last_grant_next;
    logic [1:0]        mask_reg, mask_next;
    logic [WD_W-1:0]   wd_cnt_reg, wd_cnt_next;
    logic              err_conflict_reg, err_conflict_next;
    logic              err_timeout_reg, err_timeout_next;

    logic [ADDR_W-1:0] addr_a  [2];
    logic [DATA_W-1:0] wdata_a [2];
    logic [SIZE_W-1:0] size_a  [2];
    logic [1:0]        eligible;
    logic [1:0]        conflict;
    logic              done;

    // Per-channel unpacking: a channel is eligible only with exactly one of
    // oe/we high and when it did not just complete (mask).
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_ch
            assign addr_a[gi]   = bus.ch_addr[gi*ADDR_W +: ADDR_W];
            assign wdata_a[gi]  = bus.ch_wdata[gi*DATA_W +: DATA_W];
            assign size_a[gi]   = bus.ch_size[gi*SIZE_W +: SIZE_W];
            assign conflict[gi] = bus.ch_oe[gi] & bus.ch_we[gi];
            assign eligible[gi] = (bus.ch_oe[gi] ^ bus.ch_we[gi]) & ~mask_reg[gi];
        end
    endgenerate

    // Transaction ends on memory completion or when the watchdog expires.
    assign done = (state_reg == BUSY) && (bus.mem_rdy || (wd_cnt_reg == WD_LAST));

    // State and bookkeeping registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg        <= IDLE;
            grant_reg        <= 1'b0;
            last_grant_reg   <= 1'b1;
            mask_reg         <= 2'b00;
            wd_cnt_reg       <= '0;
            err_conflict_reg <= 1'b0;
            err_timeout_reg  <= 1'b0;
        end else begin
            state_reg        <= state_next;
            grant_reg        <= grant_next;
            last_grant_reg   <= last_grant_next;
            mask_reg         <= mask_next;
            wd_cnt_reg       <= wd_cnt_next;
            err_conflict_reg <= err_conflict_next;
            err_timeout_reg  <= err_timeout_next;
        end
    end

    // Next-state: arbitrate in IDLE, count and retire in BUSY.
    always_comb begin
        state_next        = state_reg;
        grant_next        = grant_reg;
        last_grant_next   = last_grant_reg;
        mask_next         = mask_reg;
        wd_cnt_next       = wd_cnt_reg;
        err_conflict_next = err_conflict_reg;
        err_timeout_next  = err_timeout_reg;
        case (state_reg)
            IDLE: begin
                if (conflict != 2'b00) begin
                    err_conflict_next = 1'b1;
                end
                // The mask only has to cover the one IDLE cycle after completion.
                mask_next = 2'b00;
                if (eligible != 2'b00) begin
                    state_next  = BUSY;
                    wd_cnt_next = '0;
                    grant_next  = (eligible == 2'b11) ? ~last_grant_reg : eligible[1];
                end
            end
            BUSY: begin
                if (done) begin
                    state_next      = IDLE;
                    last_grant_next = grant_reg;
                    mask_next       = grant_reg ? 2'b10 : 2'b01;
                    if (!bus.mem_rdy) begin
                        err_timeout_next = 1'b1;
                    end
                end else begin
                    wd_cnt_next = wd_cnt_reg + 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Outputs: live mux of the granted channel while BUSY, zero otherwise.
    always_comb begin
        bus.mem_oe    = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        bus.mem_size  = '0;
        bus.ch_rdy    = 2'b00;
        bus.ch_rdata  = '0;
        if (!reset && state_reg == BUSY) begin
            // A granted master raising both strobes drives neither to memory.
            bus.mem_oe    = bus.ch_oe[grant_reg] & ~bus.ch_we[grant_reg];
            bus.mem_we    = bus.ch_we[grant_reg] & ~bus.ch_oe[grant_reg];
            bus.mem_addr  = addr_a[grant_reg];
            bus.mem_wdata = wdata_a[grant_reg];
            bus.mem_size  = size_a[grant_reg];
            if (done) begin
                bus.ch_rdy[grant_reg] = 1'b1;
                if (bus.mem_rdy) begin
                    if (grant_reg) begin
                        bus.ch_rdata[2*DATA_W-1:DATA_W] = bus.mem_rdata;
                    end else begin
                        bus.ch_rdata[DATA_W-1:0] = bus.mem_rdata;
                    end
                end
            end
        end
    end

    assign bus.err_conflict = err_conflict_reg & ~reset;
    assign bus.err_timeout  = err_timeout_reg & ~reset;

endmodule
